esfa_run_driver: RTL
====================

# esfa_run_driver

Synthesizable initiator for the ESFA run handshake (`doRun` / `isRunning` / `wasSuccessful`). It issues a programmed number of back-to-back runs to the ESFA core. For each run it measures the cycle count and records pass, fail and timeout tallies. It sits beside `ESFATop` on the FPGA and replaces the simulation-only benchmark stimulus, so benchmarks can be repeated on hardware.

## Interface
Parameters:
- `RUNS_W`, 16, width of run-count request and tallies
- `CNT_W`, 32, width of cycle counters
- `TIMEOUT_CYCLES`, 40000, maximum cycles allowed in each of REQ and RUN before abort

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle pulse; accepted only in IDLE or DONE
- `num_runs` in RUNS_W: runs to issue; sampled on accepted `start`
- `doRun` out 1: run request to ESFA core
- `isRunning` in 1: core executing
- `wasSuccessful` in 1: core result; valid in the first cycle `isRunning` is low after RUN
- `busy` out 1: high in REQ, RUN and GAP
- `done` out 1: high in DONE
- `pass_count`, `fail_count`, `timeout_count` out RUNS_W each: tallies
- `last_cycles` out CNT_W: cycles spent in RUN for the most recent completed run

## Operation
- States: IDLE, REQ, RUN, GAP, DONE.
- **IDLE / DONE:**
  - Accepted `start` with `num_runs`≠0: clear all tallies and `last_cycles`, load `remaining`=`num_runs`, go to REQ.
  - Accepted `start` with `num_runs`=0: go to DONE with tallies cleared.
- **REQ:**
  - `doRun`=1.
  - `isRunning`=1: go to RUN with `run_cnt`=1.
  - Wait counter reaches TIMEOUT_CYCLES: `timeout_count`++, go to GAP.
- **RUN:**
  - `doRun`=1, `run_cnt`++ each cycle `isRunning`=1.
  - `isRunning`=0: sample `wasSuccessful`, then `pass_count`++ or `fail_count`++; `last_cycles`←`run_cnt`; go to GAP.
  - `run_cnt` reaches TIMEOUT_CYCLES: `timeout_count`++, go to GAP (no pass/fail).
- **GAP:**
  - `doRun`=0.
  - Leave GAP once `isRunning` is sampled 0, at least one cycle after entry.
  - On exit `remaining`--; go to REQ if `remaining`≠0, else DONE.
  - GAP has no timeout: a core stuck with `isRunning`=1 holds the driver in GAP.
- `start` while `busy`: ignored.
- Counters saturate at all-ones and never wrap.
- Every run ends in exactly one tally, so pass+fail+timeout = runs completed.

## Timing
- Reset values:
  - `doRun`=0, `busy`=0, `done`=0, all tallies 0, `last_cycles`=0.
  - State IDLE.
- Reset mid-run: `doRun` drops in the cycle after the reset edge; the partial run is discarded.
- All outputs are registered.
- Handshake latencies:
  - `doRun` rises 1 cycle after the accepted `start`.
  - REQ→RUN transition occurs 1 cycle after `isRunning` is sampled high.
  - Result tally is updated 1 cycle after `isRunning` is sampled low.
- `isRunning` falling in the same cycle a timeout would fire: completion wins and the run is counted pass/fail.
- Minimum period per run: 1 REQ cycle + run length + 1 GAP cycle.

## Configuration
- `ESFA_RUN_DRIVER_STATS_EN` defined:
  - Adds outputs `min_cycles` and `max_cycles` (CNT_W each), updated on every pass/fail completion.
  - Reset/start values: `min_cycles`=all-ones, `max_cycles`=0.
  - Timeouts do not update them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- `esfa_bench_pkg` holds:
  - the state enum `esfa_drv_state_t`;
  - default constants `ESFA_TIMEOUT_CYCLES_DEF`=40000 and `ESFA_RUNS_W_DEF`=16.
- The package is shared with the `ESFATop` bench.
- One sub-module: `esfa_sat_counter` (parameterized width; ports `clr`, `inc`, `q`), instantiated for each tally and for `run_cnt`.

## Test plan
- **Single pass:** `num_runs`=1; stub raises `isRunning` 2 cycles after `doRun`, holds it 100 cycles, `wasSuccessful`=1 → `pass_count`=1, `last_cycles`=100, `done`=1, `doRun`=0.
- **Mixed:** `num_runs`=4, results P,F,P,F → pass=2, fail=2, timeout=0, with exactly 4 `doRun` rising edges.
- **Timeout:** stub never raises `isRunning`, TIMEOUT_CYCLES=50 → `timeout_count`=1 after 50 REQ cycles, then DONE.
- **Stuck core:** stub holds `isRunning`=1 → RUN timeout; GAP holds until `isRunning` falls, then the next REQ is issued.
- **Reset mid-RUN:** assert `reset` at cycle 30 of a run → next cycle all outputs 0, IDLE; a later `start` runs normally.
- **Edge cases:**
  - `start` while `busy` → ignored.
  - `num_runs`=0 → immediate `done` with zero tallies.
  - With STATS_EN, run lengths 10, 40, 25 → `min_cycles`=10, `max_cycles`=40.

Source files
------------

// File: rtl/esfa_bench_pkg.sv
// Shared types and defaults for the ESFA run driver and the ESFATop bench.
package esfa_bench_pkg;

  localparam int unsigned ESFA_TIMEOUT_CYCLES_DEF = 40000;
  localparam int unsigned ESFA_RUNS_W_DEF         = 16;
  localparam int unsigned ESFA_CNT_W_DEF          = 32;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StRun  = 3'd2,
    StGap  = 3'd3,
    StDone = 3'd4
  } esfa_drv_state_t;

  // Driver owns the handshake while in any of these states.
  function automatic logic drv_busy(input esfa_drv_state_t s);
    return (s == StReq) || (s == StRun) || (s == StGap);
  endfunction

  function automatic logic drv_req(input esfa_drv_state_t s);
    return (s == StReq) || (s == StRun);
  endfunction

endpackage

// File: rtl/esfa_sat_counter.sv
// Saturating up-counter with synchronous clear; clr together with inc loads 1 so a
// new measurement can start counting in the same cycle it is restarted.
module esfa_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] q
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? Width'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/esfa_run_driver.sv
// ESFA run driver: issues back-to-back doRun requests and tallies pass/fail/timeout.
// Define ESFA_RUN_DRIVER_STATS_EN to add min_cycles/max_cycles run-length statistics.
module esfa_run_driver
  import esfa_bench_pkg::*;
#(
  parameter int unsigned RUNS_W         = ESFA_RUNS_W_DEF,
  parameter int unsigned CNT_W          = ESFA_CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = ESFA_TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RUNS_W-1:0] num_runs,
  output logic              doRun,
  input  logic              isRunning,
  input  logic              wasSuccessful,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] pass_count,
  output logic [RUNS_W-1:0] fail_count,
  output logic [RUNS_W-1:0] timeout_count,
`ifdef ESFA_RUN_DRIVER_STATS_EN
  output logic [CNT_W-1:0]  min_cycles,
  output logic [CNT_W-1:0]  max_cycles,
`endif
  output logic [CNT_W-1:0]  last_cycles
);

  localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYCLES);

  esfa_drv_state_t   state_q, state_d;
  logic [RUNS_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]  last_cycles_q, last_cycles_d;
  logic              do_run_q, busy_q, done_q;

  logic              tally_clr, pass_inc, fail_inc, tmo_inc;
  logic              cnt_clr, cnt_inc;
  logic [CNT_W-1:0]  run_cnt;

  // run_cnt doubles as the REQ wait counter; both start at 1 on state entry.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    last_cycles_d = last_cycles_q;
    tally_clr     = 1'b0;
    pass_inc      = 1'b0;
    fail_inc      = 1'b0;
    tmo_inc       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          tally_clr     = 1'b1;
          last_cycles_d = '0;
          if (num_runs != '0) begin
            remaining_d = num_runs;
            state_d     = StReq;
            cnt_clr     = 1'b1;
            cnt_inc     = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (isRunning) begin
          state_d = StRun;
          cnt_clr = 1'b1;
          cnt_inc = 1'b1;
        end else if (run_cnt == TimeoutLim) begin
          tmo_inc = 1'b1;
          state_d = StGap;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StRun: begin
        // Completion is checked first so a simultaneous timeout loses.
        if (!isRunning) begin
          pass_inc      = wasSuccessful;
          fail_inc      = !wasSuccessful;
          last_cycles_d = run_cnt;
          state_d       = StGap;
        end else if (run_cnt == TimeoutLim) begin
          tmo_inc = 1'b1;
          state_d = StGap;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StGap: begin
        if (!isRunning) begin
          remaining_d = remaining_q - RUNS_W'(1);
          if (remaining_q == RUNS_W'(1)) begin
            state_d = StDone;
          end else begin
            state_d = StReq;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      last_cycles_q <= '0;
      do_run_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      last_cycles_q <= last_cycles_d;
      do_run_q      <= drv_req(state_d);
      busy_q        <= drv_busy(state_d);
      done_q        <= (state_d == StDone);
    end
  end

  esfa_sat_counter #(
    .Width (CNT_W)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .q     (run_cnt)
  );

  esfa_sat_counter #(
    .Width (RUNS_W)
  ) u_pass_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (tally_clr),
    .inc   (pass_inc),
    .q     (pass_count)
  );

  esfa_sat_counter #(
    .Width (RUNS_W)
  ) u_fail_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (tally_clr),
    .inc   (fail_inc),
    .q     (fail_count)
  );

  esfa_sat_counter #(
    .Width (RUNS_W)
  ) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (tally_clr),
    .inc   (tmo_inc),
    .q     (timeout_count)
  );

`ifdef ESFA_RUN_DRIVER_STATS_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (tally_clr) begin
      min_d = '1;
      max_d = '0;
    end else if (pass_inc || fail_inc) begin
      if (run_cnt < min_q) min_d = run_cnt;
      if (run_cnt > max_q) max_d = run_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_cycles = min_q;
  assign max_cycles = max_q;
`else
  // Run-length statistics compiled out.
`endif

  assign doRun       = do_run_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign last_cycles = last_cycles_q;

endmodule
